// File: rtl/inst_loader.sv
// Program loader: packs a host byte stream into 32-bit words and fills imem from address 0, then releases the core.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word after the end sentinel.
module inst_loader #(
  parameter int          ADDR_W     = 8,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              core_valid,
  input  logic              opr_finished,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK = 3'd5
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST_END = S_CHECK;
`else
  localparam state_t S_POST_END = S_RUN;
`endif
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state, state_nx;
  logic [1:0]  byte_idx;
  logic [23:0] held;
  logic [31:0] word;
  logic        accept, last_byte, is_end, full, load_go, do_write;

  // Handshake: a byte transfers on any rising edge with byte_valid && byte_ready;
  // byte_ready depends on state only, never on byte_valid.
  assign accept    = byte_valid && byte_ready;
  assign last_byte = accept && (byte_idx == 2'd3);
  assign word      = BIG_ENDIAN ? {held, byte_data} : {byte_data, held};
  assign is_end    = (word == END_WORD);
  assign full      = word_count[ADDR_W];
  assign load_go   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign do_write  = last_byte && (state == S_LOAD) && !is_end && !full;
  assign dbg_state = state;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        acc <= '0;
    else if (load_go)  acc <= '0;
    else if (do_write) acc <= acc + word;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (last_byte) begin
          if (is_end)    state_nx = (word_count == '0) ? S_ERR : S_POST_END;
          else if (full) state_nx = S_ERR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (last_byte) state_nx = (word == acc) ? S_RUN : S_ERR;
`endif
      S_RUN: if (opr_finished) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    core_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_LOAD: begin byte_ready = 1'b1; busy = 1'b1; end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin byte_ready = 1'b1; busy = 1'b1; end
`endif
      S_RUN:  begin core_valid = 1'b1; busy = 1'b1; end
      S_DONE: done = 1'b1;
      S_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  // held keeps the first three bytes already placed so the 4th byte completes the word combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx   <= '0;
      held       <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (load_go) begin
        byte_idx   <= '0;
        held       <= '0;
        word_count <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        held     <= BIG_ENDIAN ? {held[15:0], byte_data} : {byte_data, held[23:8]};
        if (do_write) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= word;
          word_count <= word_count + ONE;
        end
      end
    end
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program loader on the write side of the pipeline's instruction memory. The fetch stage only reads that memory; this block fills it.
- Accepts a byte stream from the bench/host and packs it into 32-bit instruction words. Writes the words sequentially into imem from address 0.
- Detects the end-of-program sentinel, then raises core_valid to release the pipeline. Waits for opr_finished from the core and reports done.

Parameters:
ADDR_W, 8, imem word-address width; capacity 2**ADDR_W words
BIG_ENDIAN, 1, 1: first byte of a word goes to [31:24]; 0: first byte goes to [7:0]
END_WORD, 32'hFFFF_FFFF, sentinel word that terminates the program (never written to imem)

Ports:
clk  in  1  single clock; all state changes on rising edge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  begin (re)load; honoured in IDLE, DONE, ERR only
byte_valid  in  1  byte_data is valid
byte_data  in  8  program byte
byte_ready  out  1  loader can accept a byte
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  instruction word for the write
word_count  out  ADDR_W+1  words written so far
core_valid  out  1  program loaded, core may run (drives pipeline valid)
opr_finished  in  1  core reports completion
busy  out  1  high in LOAD, CHECK, RUN
done  out  1  high in DONE
err  out  1  high in ERR (empty program, overflow, checksum mismatch)

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0: byte_ready, imem_we, imem_addr, imem_wdata, word_count, core_valid, busy, done, err. Byte index, partial word and checksum accumulator are cleared.
- States: IDLE, LOAD, CHECK (only with the feature), RUN, DONE, ERR.
- IDLE/DONE/ERR to LOAD: start=1 moves to LOAD on the next edge. Entering LOAD clears word_count, byte index, partial word, accumulator, done and err. byte_ready=1 from the first LOAD cycle.
- start in LOAD, CHECK or RUN is ignored.
- Byte handshake: a byte is accepted on a clock edge where byte_valid&&byte_ready. byte_ready=1 throughout LOAD/CHECK (no backpressure) and 0 elsewhere. A 2-bit index wraps 3 to 0.
- Word completion: on the 4th accepted byte, the assembled word is compared with END_WORD. The compare uses the incoming byte combined with the 3 stored bytes.
  - Non-sentinel, word_count < 2**ADDR_W: on the next cycle imem_we=1 for exactly one cycle, with imem_addr=word_count[ADDR_W-1:0] and imem_wdata=word. word_count increments on the same edge. Latency is 1 cycle from the 4th byte handshake to the strobe.
  - Non-sentinel, word_count == 2**ADDR_W: no write; go to ERR (overflow).
  - Sentinel, word_count == 0: go to ERR (empty program).
  - Sentinel, word_count > 0: go to CHECK (feature on) or RUN (feature off). The sentinel is never written.
- Back-to-back words: at most one write per 4 byte handshakes, so no write collisions can occur.
- RUN: core_valid=1, byte_ready=0. When opr_finished is sampled 1, go to DONE: core_valid=0, done=1. opr_finished is ignored outside RUN.
- DONE/ERR: imem contents are left as written. word_count holds its value until the next start.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-operation: the partial word is discarded and no further imem_we is issued. A reload starts at address 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Each written word is added into a 32-bit accumulator with modulo-2^32 wrap. The sentinel is excluded.
  - After a valid sentinel, the FSM enters CHECK and accepts exactly 4 more bytes as a checksum word, using the same endianness.
  - Equal to the accumulator: go to RUN. Unequal: go to ERR, with no core_valid.
- Undefined:
  - No CHECK state and no accumulator. The sentinel (with word_count>0) goes directly to RUN. No extra bytes are consumed.

Test Plan:
- Load words 0x20010005, 0x20020003, 0x00221820, then END, BIG_ENDIAN=1, byte_valid continuous -> three single-cycle imem_we pulses at addr 0/1/2 with those data. word_count=3, then core_valid=1. Pulse opr_finished -> done=1, core_valid=0, busy=0.
- Same program with byte_valid toggling 1-0-1 and 3-cycle gaps -> identical writes and identical word_count=3. BIG_ENDIAN=0 with reversed byte order -> same words.
- Program of only END -> no imem_we, err=1, core_valid stays 0. Then start -> err=0, back in LOAD.
- ADDR_W=2, send 5 words + END -> 4 writes (addr 0..3), word_count=4, then err=1 on the 5th word and no 5th write.
- Assert reset=0 after 6 bytes of a load -> outputs 0 immediately (async). Release and start, load 1 word + END -> write at addr 0, word_count=1.
- LOADER_CHECKSUM_EN: words 0x00000001, 0x00000002, END, checksum 0x00000003 -> RUN, core_valid=1. Checksum 0x00000004 -> ERR, err=1, core_valid=0.
